// File: rtl/phase_meter.sv
// Phase meter: measures the ref_in period and the ref-rise to sig-rise delay in clk
// cycles, optionally averaged over 2^AVG_LOG2 periods before being presented.
module phase_meter #(
  parameter int W        = 16,
  parameter int AVG_LOG2 = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         ref_in,
  input  logic         sig_in,
  output logic [W-1:0] period_out,
  output logic [W-1:0] phase_out,
  output logic         meas_valid,
  output logic         no_sig,
  output logic         overflow
);
  localparam int AW = W + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] AVG_N = CW'(1) << AVG_LOG2;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Bit 0 carries ref_in, bit 1 carries sig_in: identical latency on both paths.
  logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d, rise_q, rise_d;
  logic       ref_rise, sig_rise;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   ph_cap_q, ph_cap_d;
  logic           got_sig_q, got_sig_d;
  logic [AW-1:0]  per_acc_q, per_acc_d;
  logic [AW-1:0]  ph_acc_q, ph_acc_d;
  logic [CW-1:0]  avg_cnt_q, avg_cnt_d;
  logic [W-1:0]   period_out_q, period_out_d;
  logic [W-1:0]   phase_out_q, phase_out_d;
  logic           valid_q, valid_d;
  logic           no_sig_q, no_sig_d;
  logic           ovf_q, ovf_d;

  logic [AW-1:0]  per_sum, ph_sum;
  logic [CW-1:0]  avg_inc;

  always_comb begin
    sync1_d = {sig_in, ref_in};
    sync2_d = sync1_q;
    dly_d   = sync2_q;
    rise_d  = sync2_q & ~dly_q;
  end

  assign ref_rise = rise_q[0];
  assign sig_rise = rise_q[1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ph_cap_d     = ph_cap_q;
    got_sig_d    = got_sig_q;
    per_acc_d    = per_acc_q;
    ph_acc_d     = ph_acc_q;
    avg_cnt_d    = avg_cnt_q;
    period_out_d = period_out_q;
    phase_out_d  = phase_out_q;
    valid_d      = 1'b0;
    no_sig_d     = no_sig_q;
    ovf_d        = ovf_q;

    per_sum = per_acc_q + AW'(cnt_q);
    ph_sum  = ph_acc_q + AW'(ph_cap_q);
    avg_inc = avg_cnt_q + CW'(1);

    if (!en) begin
      state_d   = IDLE;
      per_acc_d = '0;
      ph_acc_d  = '0;
      avg_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ref_rise) begin
            state_d   = RUN;
            cnt_d     = W'(1);
            got_sig_d = sig_rise;
            ph_cap_d  = '0;
          end
        end
        RUN: begin
          if (ref_rise) begin
            if (got_sig_q) begin
              no_sig_d = 1'b0;
              ovf_d    = 1'b0;
              // The final period of a batch is folded straight into the result.
              if (avg_inc == AVG_N) begin
                period_out_d = W'(per_sum >> AVG_LOG2);
                phase_out_d  = W'(ph_sum >> AVG_LOG2);
                valid_d      = 1'b1;
                per_acc_d    = '0;
                ph_acc_d     = '0;
                avg_cnt_d    = '0;
              end else begin
                per_acc_d = per_sum;
                ph_acc_d  = ph_sum;
                avg_cnt_d = avg_inc;
              end
            end else begin
              no_sig_d  = 1'b1;
              per_acc_d = '0;
              ph_acc_d  = '0;
              avg_cnt_d = '0;
            end
            cnt_d     = W'(1);
            got_sig_d = sig_rise;
            ph_cap_d  = '0;
          end else if (cnt_q == '1) begin
            ovf_d     = 1'b1;
            per_acc_d = '0;
            ph_acc_d  = '0;
            avg_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + W'(1);
            if (sig_rise && !got_sig_q) begin
              got_sig_d = 1'b1;
              ph_cap_d  = cnt_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      dly_q        <= '0;
      rise_q       <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      ph_cap_q     <= '0;
      got_sig_q    <= 1'b0;
      per_acc_q    <= '0;
      ph_acc_q     <= '0;
      avg_cnt_q    <= '0;
      period_out_q <= '0;
      phase_out_q  <= '0;
      valid_q      <= 1'b0;
      no_sig_q     <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      dly_q        <= dly_d;
      rise_q       <= rise_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ph_cap_q     <= ph_cap_d;
      got_sig_q    <= got_sig_d;
      per_acc_q    <= per_acc_d;
      ph_acc_q     <= ph_acc_d;
      avg_cnt_q    <= avg_cnt_d;
      period_out_q <= period_out_d;
      phase_out_q  <= phase_out_d;
      valid_q      <= valid_d;
      no_sig_q     <= no_sig_d;
      ovf_q        <= ovf_d;
    end
  end

  assign period_out = period_out_q;
  assign phase_out  = phase_out_q;
  assign meas_valid = valid_q;
  assign no_sig     = no_sig_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_phase_meter.sv
// Bench for phase_meter: two instances (no averaging, 4-period averaging) share the
// stimulus; a cycle-accurate model built from edge times is compared every cycle.
module tb_phase_meter;
  localparam int W    = 12;
  localparam int MAXC = (1 << W) - 1;
  localparam int HI   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b1;
  logic ref_in = 1'b0;
  logic sig_in = 1'b0;
  logic [W-1:0] per0, ph0, per2, ph2;
  logic mv0, mv2, ns0, ns2, ov0, ov2;

  always #5 clk = ~clk;

  phase_meter #(.W(W), .AVG_LOG2(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .ref_in(ref_in), .sig_in(sig_in),
    .period_out(per0), .phase_out(ph0), .meas_valid(mv0), .no_sig(ns0), .overflow(ov0));

  phase_meter #(.W(W), .AVG_LOG2(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .ref_in(ref_in), .sig_in(sig_in),
    .period_out(per2), .phase_out(ph2), .meas_valid(mv2), .no_sig(ns2), .overflow(ov2));

  // kind 0: result strobe, 1: flag update, 2: reset
  typedef struct { int eff; int kind; int inst; int per; int ph; bit ns; bit ov; } ev_t;
  typedef struct { int per; int pa; int pb; int n; int x_per; int x_ph; bit x_ns; } row_t;

  ev_t  evq[$];
  row_t rows[5];
  int   cyc = 0, n_cmp = 0, n_bad = 0;
  bit   done = 1'b0;
  bit   open_v = 1'b0, got = 1'b0, m_ns = 1'b0, m_ov = 1'b0;
  int   open_t = 0, ph_m = 0;
  int   acc_p[2], acc_h[2], acc_n[2];
  int   lg[2] = '{0, 2};
  int   e_per[2] = '{0, 0};
  int   e_ph[2]  = '{0, 0};
  bit   e_ns = 1'b0, e_ov = 1'b0;
  bit   prev_ref = 1'b0, prev_sig = 1'b0;
  int   s0_cnt = 0, s2_cnt = 0;
  int   base;

  task automatic finish_bench();
    if (!done) begin
      done = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    if (!done) begin
      n_cmp++;
      if (act != exp) begin
        n_bad++;
        $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        if (n_bad >= 40) finish_bench();
      end
    end
  endtask

  function automatic void push_ev(input int eff, input int kind, input int inst,
                                  input int per, input int ph, input bit ns, input bit ov);
    ev_t e;
    e.eff = eff; e.kind = kind; e.inst = inst; e.per = per; e.ph = ph; e.ns = ns; e.ov = ov;
    evq.push_back(e);
  endfunction

  function automatic void clear_acc();
    for (int k = 0; k < 2; k++) begin
      acc_p[k] = 0; acc_h[k] = 0; acc_n[k] = 0;
    end
  endfunction

  function automatic bit win(input int c, input int x);
    return (x >= 0) && (c >= x) && (c < x + HI);
  endfunction

  // Reference model: works on edge times; every effect appears 4 cycles after the edge.
  task automatic model_cycle(input bit rr, input bit sr);
    int t;
    t = cyc;
    if (!rst || !en) return;
    if (rr) begin
      if (open_v) begin
        if (got) begin
          m_ns = 1'b0; m_ov = 1'b0;
          push_ev(t + 4, 1, 0, 0, 0, m_ns, m_ov);
          for (int k = 0; k < 2; k++) begin
            acc_p[k] += t - open_t;
            acc_h[k] += ph_m;
            acc_n[k]++;
            if (acc_n[k] == (1 << lg[k])) begin
              push_ev(t + 4, 0, k, acc_p[k] >> lg[k], acc_h[k] >> lg[k], 1'b0, 1'b0);
              acc_p[k] = 0; acc_h[k] = 0; acc_n[k] = 0;
            end
          end
        end else begin
          m_ns = 1'b1;
          push_ev(t + 4, 1, 0, 0, 0, m_ns, m_ov);
          clear_acc();
        end
      end
      open_v = 1'b1; open_t = t; got = 1'b0;
    end else if (open_v && (t - open_t == MAXC)) begin
      m_ov = 1'b1;
      push_ev(t + 4, 1, 0, 0, 0, m_ns, m_ov);
      open_v = 1'b0;
      clear_acc();
    end
    if (sr && open_v && !got) begin
      got = 1'b1;
      ph_m = t - open_t;
    end
  endtask

  task automatic monitor_cycle();
    bit sv0, sv1;
    ev_t e;
    sv0 = 1'b0; sv1 = 1'b0;
    while (evq.size() > 0 && evq[0].eff <= cyc) begin
      e = evq.pop_front();
      case (e.kind)
        0: begin
          e_per[e.inst] = e.per; e_ph[e.inst] = e.ph;
          if (e.inst == 0) sv0 = 1'b1; else sv1 = 1'b1;
        end
        1: begin e_ns = e.ns; e_ov = e.ov; end
        default: begin
          e_per = '{0, 0}; e_ph = '{0, 0}; e_ns = 1'b0; e_ov = 1'b0;
        end
      endcase
    end
    check("valid0",   int'(mv0),  int'(sv0));
    check("period0",  int'(per0), e_per[0]);
    check("phase0",   int'(ph0),  e_ph[0]);
    check("no_sig0",  int'(ns0),  int'(e_ns));
    check("ovf0",     int'(ov0),  int'(e_ov));
    check("valid2",   int'(mv2),  int'(sv1));
    check("period2",  int'(per2), e_per[1]);
    check("phase2",   int'(ph2),  e_ph[1]);
    check("no_sig2",  int'(ns2),  int'(e_ns));
    check("ovf2",     int'(ov2),  int'(e_ov));
    s0_cnt += int'(mv0);
    s2_cnt += int'(mv2);
  endtask

  task automatic step(input bit r, input bit s);
    @(posedge clk);
    cyc++;
    #1;
    ref_in = r;
    sig_in = s;
    model_cycle(r & ~prev_ref, s & ~prev_sig);
    prev_ref = r;
    prev_sig = s;
    @(negedge clk);
    monitor_cycle();
  endtask

  task automatic run_cycles(input int p, input int a, input int b, input int len);
    for (int c = 0; c < len; c++) step(c < p / 2, win(c, a) || win(c, b));
  endtask

  task automatic run_period(input int p, input int a, input int b);
    run_cycles(p, a, b, p);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    push_ev(cyc + 1, 2, 0, 0, 0, 1'b0, 1'b0);
    open_v = 1'b0; got = 1'b0; m_ns = 1'b0; m_ov = 1'b0;
    clear_acc();
    repeat (n) step(1'b0, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    clear_acc();
    rows[0] = '{1250, 100,  -1, 5, 1250, 100, 1'b0};
    rows[1] = '{1250,   0,  -1, 3, 1250,   0, 1'b0};
    rows[2] = '{1250,  40, 300, 3, 1250,  40, 1'b0};
    rows[3] = '{1250,  -1,  -1, 2, 1250,  40, 1'b1};
    rows[4] = '{1250, 200,  -1, 2, 1250, 200, 1'b0};

    repeat (3) step(1'b0, 1'b0);
    rst = 1'b1;
    repeat (5) step(1'b0, 1'b0);
    check("reset_period", int'(per0), 0);
    check("reset_valid",  int'(mv0),  0);

    for (int i = 0; i < 5; i++) begin
      base = s0_cnt;
      repeat (rows[i].n) run_period(rows[i].per, rows[i].pa, rows[i].pb);
      check($sformatf("row%0d_period", i), int'(per0), rows[i].x_per);
      check($sformatf("row%0d_phase", i),  int'(ph0),  rows[i].x_ph);
      check($sformatf("row%0d_no_sig", i), int'(ns0),  int'(rows[i].x_ns));
      check($sformatf("row%0d_ovf", i),    int'(ov0),  0);
      if (i == 0) check("row0_strobes", s0_cnt - base, 4);
    end

    // Counter saturation, then relock.
    run_period(MAXC + 200, 100, -1);
    check("ovf_set",       int'(ov0),  1);
    check("ovf_hold_ph",   int'(ph0),  200);
    check("ovf_hold_per",  int'(per0), 1250);
    base = s0_cnt;
    run_period(1250, 100, -1);
    check("ovf_open_no_strobe", s0_cnt - base, 0);
    check("ovf_still_set",      int'(ov0), 1);
    run_period(1250, 100, -1);
    check("ovf_cleared", int'(ov0), 0);
    check("relock_ph",   int'(ph0), 100);

    // Reset in the middle of a period.
    run_period(1250, 100, -1);
    run_cycles(1250, 100, -1, 700);
    do_reset(3);
    check("midrst_period", int'(per0), 0);
    check("midrst_phase",  int'(ph0),  0);
    base = s0_cnt;
    repeat (3) run_period(1250, 150, -1);
    check("post_rst_strobes", s0_cnt - base, 2);
    check("post_rst_phase",   int'(ph0), 150);

    // Averaging over four periods.
    do_reset(4);
    base = s2_cnt;
    for (int i = 0; i < 9; i++) run_period(1250, 100 + (i % 4), -1);
    check("avg_strobes", s2_cnt - base, 2);
    check("avg_phase",   int'(ph2),  101);
    check("avg_period",  int'(per2), 1250);
    check("avg_last_ph0", int'(ph0), 103);

    // Enable dropped while the averaging instance is mid-accumulation.
    base = s2_cnt;
    run_period(1250, 100, -1);
    run_period(1250, 100, -1);
    run_cycles(1250, 100, -1, 700);
    en = 1'b0;
    open_v = 1'b0; got = 1'b0;
    clear_acc();
    repeat (50) step(1'b0, 1'b0);
    en = 1'b1;
    repeat (3) run_period(1250, 60, -1);
    check("en_no_strobe2", s2_cnt - base, 0);
    check("en_hold_ph2",   int'(ph2), 101);
    check("en_hold_per2",  int'(per2), 1250);
    check("en_ph0",        int'(ph0), 60);

    // Random periods, phases, missing and double sig edges.
    for (int i = 0; i < 40; i++) begin
      int p, a, b;
      p = int'($urandom_range(400, 40));
      a = -1;
      b = -1;
      if ($urandom_range(9, 0) != 0) begin
        a = int'($urandom_range(p - HI - 2, 0));
        if ((a + HI + 2 <= p - HI - 2) && ($urandom_range(1, 0) == 1))
          b = int'($urandom_range(p - HI - 2, a + HI + 1));
      end
      run_period(p, a, b);
    end
    repeat (10) step(1'b0, 1'b0);
    finish_bench();
  end

endmodule
